// File: rtl/jtcop_dump_sched.sv
// Frame-windowed dump scheduler: counts vs falling edges and opens a dump window of len frames at start_frame.
// Build option: define JTCOP_DUMP_REPEAT_EN to re-arm after each window (periodic windows every REPEAT_GAP frames).
module jtcop_dump_sched #(
  parameter bit WAIT_DWNLD = 1'b1,
  parameter int CW         = 32,
  parameter int LW         = 16,
  parameter int REPEAT_GAP = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          dwnld,
  input  logic          enable,
  input  logic [CW-1:0] start_frame,
  input  logic [LW-1:0] len,
  output logic [CW-1:0] frame_cnt,
  output logic          dump_on,
  output logic          dump_start,
  output logic          dump_stop,
  output logic [2:0]    st
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOAD = 3'd1,
    ARMED     = 3'd2,
    DUMPING   = 3'd3,
    DONE      = 3'd4
  } state_t;

  typedef struct packed {
    state_t        st;
    logic [CW-1:0] target;
    logic [LW-1:0] remaining;
    logic [LW-1:0] len_q;
    logic          on;
    logic          start;
    logic          stop;
  } sched_t;

  sched_t cur, nxt;
  logic   vs_l, dwnld_l;
  logic   vs_fall, dl_fall, dl_rise;

  assign vs_fall = vs_l & ~vs;
  assign dl_fall = dwnld_l & ~dwnld;
  assign dl_rise = ~dwnld_l & dwnld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_l      <= 1'b1;
      dwnld_l   <= 1'b0;
      frame_cnt <= '0;
      cur       <= '0;
    end else begin
      vs_l      <= vs;
      dwnld_l   <= dwnld;
      frame_cnt <= frame_cnt + CW'(vs_fall);
      cur       <= nxt;
    end
  end

  always_comb begin
    nxt       = cur;
    nxt.start = 1'b0;
    nxt.stop  = 1'b0;
    if (!enable) begin
      nxt.st   = IDLE;
      nxt.on   = 1'b0;
      nxt.stop = cur.on;
    end else if (WAIT_DWNLD && dl_rise && (cur.st == ARMED || cur.st == DUMPING)) begin
      // a new download invalidates the capture; wait for it to finish again
      nxt.st   = WAIT_LOAD;
      nxt.on   = 1'b0;
      nxt.stop = cur.on;
    end else begin
      case (cur.st)
        IDLE: begin
          nxt.st     = WAIT_DWNLD ? WAIT_LOAD : ARMED;
          nxt.target = start_frame;
          nxt.len_q  = len;
        end
        WAIT_LOAD: if (dl_fall) nxt.st = ARMED;
        ARMED: if (vs_fall && frame_cnt == cur.target) begin
          nxt.st        = DUMPING;
          nxt.on        = 1'b1;
          nxt.start     = 1'b1;
          nxt.remaining = cur.len_q;
        end
        DUMPING: if (vs_fall && cur.remaining != '0) begin
          nxt.remaining = cur.remaining - 1'b1;
          if (cur.remaining == LW'(1)) begin
            nxt.st   = DONE;
            nxt.on   = 1'b0;
            nxt.stop = 1'b1;
          end
        end
        DONE: begin
`ifdef JTCOP_DUMP_REPEAT_EN
          // frame_cnt is exactly one past the closing frame here, so the gap counts from that frame
          nxt.st     = ARMED;
          nxt.target = frame_cnt + CW'(REPEAT_GAP - 1);
          nxt.len_q  = len;
`else
          nxt.st     = DONE;
`endif
        end
        default: nxt.st = IDLE;
      endcase
    end
  end

  assign dump_on    = cur.on;
  assign dump_start = cur.start;
  assign dump_stop  = cur.stop;
  assign st         = cur.st;

endmodule
